// File: rtl/studio2_pkg.sv
// +----------------------------------------------------------------------+
// | Module   : studio2_pkg                                               |
// | Purpose  : Shared constants, types and key-select helper for the     |
// |            Studio II keypad interface.                               |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

package studio2_pkg;

  // CPU output port that carries the key select (OUT 2)
  localparam logic [2:0] KEY_PORT     = 3'd2;
  // Keys per player pad
  localparam int         NUM_KEYS     = 10;
  // Select value after reset: matches no key
  localparam logic [3:0] KEY_SEL_NONE = 4'hF;
  // Positions of the player flags within the EF contribution
  localparam int         EF_P1        = 2;
  localparam int         EF_P2        = 3;

  typedef logic [NUM_KEYS-1:0] keyvec_t;

  // Bit of a pad vector chosen by a 4-bit select; selects above 9 read 0
  function automatic logic key_pick(input keyvec_t vec, input logic [3:0] sel);
    logic bit_v;
    bit_v = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (sel == 4'(i)) bit_v = vec[i];
    end
    return bit_v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/studio2_keypad_debounce.sv
// +----------------------------------------------------------------------+
// | Module   : studio2_keypad_debounce                                   |
// | Purpose  : Two-flop synchroniser plus optional debounce filter for   |
// |            one 10-key pad. Filter built only with KEYPAD_DEBOUNCE_EN; |
// |            otherwise the synchronised vector is passed straight on.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module studio2_keypad_debounce
  import studio2_pkg::*;
#(
  parameter int DEBOUNCE = 20000,
  parameter int CNT_W    = 16
) (
  input  logic    clk,
  input  logic    reset,
  input  keyvec_t raw_i,
  output keyvec_t stable_o
);

  // Reject configurations the counter cannot represent
  if ((DEBOUNCE < 1) || (DEBOUNCE > 65535) ||
      ((CNT_W < 32) && ((64'd1 << CNT_W) <= 64'(DEBOUNCE)))) begin : g_bad_cfg
    $error("studio2_keypad_debounce: DEBOUNCE/CNT_W out of range");
  end

  keyvec_t sync1_q, sync2_q;

  // Two-flop chain bringing the asynchronous pad lines into the clk domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef KEYPAD_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  keyvec_t          cand_q, cand_d;
  keyvec_t          stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Restart the count on any change; commit the candidate once it has held long enough
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) stable_d = cand_q;
    end
  end

  // Candidate, saturating counter and committed vector
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
`else
  assign stable_o = sync2_q;
`endif

endmodule

`default_nettype wire

// File: rtl/studio2_keypad.sv
// +----------------------------------------------------------------------+
// | Module   : studio2_keypad                                            |
// | Purpose  : Studio II keypad interface. Latches the key number from   |
// |            OUT 2 and drives EF3/EF4 while the selected key of player |
// |            1/2 is held. Debounce filter enabled by KEYPAD_DEBOUNCE_EN.|
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module studio2_keypad
  import studio2_pkg::*;
#(
  parameter int DEBOUNCE = 20000,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] keys_p1,
  input  logic [9:0] keys_p2,
  input  logic       io_out,
  input  logic [2:0] io_n,
  input  logic [7:0] io_dout,
  output logic [3:0] key_sel,
  output logic [3:0] key_ef
);

  keyvec_t    stable_p1, stable_p2;
  logic [3:0] key_sel_q, key_sel_d;
  logic [3:0] key_ef_q, key_ef_d;
  logic       unused_dout_hi;

  // Upper data nibble carries no meaning for the key select
  assign unused_dout_hi = ^io_dout[7:4];

  studio2_keypad_debounce #(
    .DEBOUNCE (DEBOUNCE),
    .CNT_W    (CNT_W)
  ) u_pad_p1 (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (keys_p1),
    .stable_o (stable_p1)
  );

  studio2_keypad_debounce #(
    .DEBOUNCE (DEBOUNCE),
    .CNT_W    (CNT_W)
  ) u_pad_p2 (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (keys_p2),
    .stable_o (stable_p2)
  );

  // Select latch from OUT 2 and per-player EF lookup of the current select
  always_comb begin
    key_sel_d = key_sel_q;
    if (io_out && (io_n == KEY_PORT)) key_sel_d = io_dout[3:0];
    key_ef_d        = '0;
    key_ef_d[EF_P1] = key_pick(stable_p1, key_sel_q);
    key_ef_d[EF_P2] = key_pick(stable_p2, key_sel_q);
  end

  // Select and EF registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_sel_q <= KEY_SEL_NONE;
      key_ef_q  <= '0;
    end else begin
      key_sel_q <= key_sel_d;
      key_ef_q  <= key_ef_d;
    end
  end

  assign key_sel = key_sel_q;
  assign key_ef  = key_ef_q;

endmodule

`default_nettype wire

// File: tb/tb_studio2_keypad.sv
`default_nettype none

module tb_studio2_keypad;

  localparam int D = 4;
`ifdef KEYPAD_DEBOUNCE_EN
  localparam int LAT = D + 4;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] keys_p1, keys_p2;
  logic       io_out;
  logic [2:0] io_n;
  logic [7:0] io_dout;
  logic [3:0] key_sel, key_ef;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: recent pad history (index 0 = value applied
  // during the cycle that ends at the current edge), committed vectors,
  // select and EF as seen after the current edge.
  logic [9:0] h1 [0:15];
  logic [9:0] h2 [0:15];
  logic [9:0] m_st1, m_st2;
  logic [3:0] m_sel, m_ef;

  studio2_keypad #(.DEBOUNCE(D), .CNT_W(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .keys_p1 (keys_p1),
    .keys_p2 (keys_p2),
    .io_out  (io_out),
    .io_n    (io_n),
    .io_dout (io_dout),
    .key_sel (key_sel),
    .key_ef  (key_ef)
  );

  always #5 clk = ~clk;

  function automatic logic pick(input logic [9:0] v, input logic [3:0] s);
    if (s > 4'd9) return 1'b0;
    return v[s];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      h1[i] = '0;
      h2[i] = '0;
    end
    m_st1 = '0;
    m_st2 = '0;
    m_sel = 4'hF;
    m_ef  = 4'h0;
  endtask

  // Advance the model across one rising edge using the inputs held before it
  task automatic model_edge();
    logic [3:0] ef_n;
    bit ok1, ok2;
    if (!reset) begin
      model_reset();
      return;
    end
    ef_n    = 4'h0;
    ef_n[2] = pick(m_st1, m_sel);
    ef_n[3] = pick(m_st2, m_sel);
    if (io_out && io_n == 3'd2) m_sel = io_dout[3:0];
    m_ef = ef_n;
    for (int i = 15; i > 0; i--) begin
      h1[i] = h1[i-1];
      h2[i] = h2[i-1];
    end
    h1[0] = keys_p1;
    h2[0] = keys_p2;
`ifdef KEYPAD_DEBOUNCE_EN
    // A level is committed once D+1 consecutive synchronised samples agree
    ok1 = 1'b1;
    ok2 = 1'b1;
    for (int i = 3; i <= D + 2; i++) begin
      if (h1[i] != h1[2]) ok1 = 1'b0;
      if (h2[i] != h2[2]) ok2 = 1'b0;
    end
    if (ok1) m_st1 = h1[2];
    if (ok2) m_st2 = h2[2];
`else
    ok1 = 1'b0;
    ok2 = 1'b0;
    m_st1 = h1[1];
    m_st2 = h2[1];
`endif
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("key_sel", key_sel, m_sel);
    check("key_ef", key_ef, m_ef);
  endtask

  task automatic cpu_out(input logic [2:0] port, input logic [7:0] data);
    io_out  = 1'b1;
    io_n    = port;
    io_dout = data;
    tick();
    io_out  = 1'b0;
    io_n    = 3'd0;
    io_dout = 8'h00;
  endtask

  initial begin
    reset   = 1'b0;
    keys_p1 = '0;
    keys_p2 = '0;
    io_out  = 1'b0;
    io_n    = 3'd0;
    io_dout = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel", key_sel, 4'hF);
    check("rst_ef", key_ef, 4'h0);
    reset = 1'b1;

    // Idle after reset
    repeat (100) tick();
    check("idle_sel", key_sel, 4'hF);
    check("idle_ef", key_ef, 4'h0);

    // Player 1 key 5 press and release latency
    cpu_out(3'd2, 8'h05);
    check("sel5", key_sel, 4'h5);
    keys_p1[5] = 1'b1;
    repeat (LAT - 1) tick();
    check("p1_pre_rise", key_ef, 4'h0);
    tick();
    check("p1_rise", key_ef, 4'h4);
    keys_p1[5] = 1'b0;
    repeat (LAT - 1) tick();
    check("p1_pre_fall", key_ef, 4'h4);
    tick();
    check("p1_fall", key_ef, 4'h0);

    // Player 2 key 5 bouncing, then held
    for (int t = 0; t < 10; t++) begin
      keys_p2[5] = ~keys_p2[5];
      repeat (3) begin
        tick();
`ifdef KEYPAD_DEBOUNCE_EN
        check("p2_bounce", {3'b000, key_ef[3]}, 4'h0);
`endif
      end
    end
    keys_p2[5] = 1'b1;
    repeat (LAT - 1) tick();
    check("p2_pre_rise", {3'b000, key_ef[3]}, 4'h0);
    tick();
    check("p2_rise", {3'b000, key_ef[3]}, 4'h1);
    keys_p2 = '0;
    repeat (LAT + 1) tick();

    // Both pads key 3; select changes to no-key and back
    keys_p1[3] = 1'b1;
    keys_p2[3] = 1'b1;
    cpu_out(3'd2, 8'h03);
    repeat (LAT) tick();
    check("both3", key_ef, 4'hC);
    cpu_out(3'd2, 8'h0A);
    tick();
    check("sel_none", key_ef, 4'h0);
    cpu_out(3'd2, 8'h03);
    tick();
    check("both3_again", key_ef, 4'hC);

    // Port qualification and upper nibble masking
    cpu_out(3'd1, 8'h02);
    check("port1_ignored", key_sel, 4'h3);
    cpu_out(3'd2, 8'hF7);
    check("sel_f7", key_sel, 4'h7);
    keys_p1 = '0;
    keys_p2 = '0;
    repeat (LAT + 1) tick();

    // Reset in the middle of debouncing, key held through reset
    cpu_out(3'd2, 8'h00);
    keys_p1[0] = 1'b1;
    repeat (5) tick();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("midrst_ef", key_ef, 4'h0);
    check("midrst_sel", key_sel, 4'hF);
    tick();
    tick();
    reset = 1'b1;
    cpu_out(3'd2, 8'h00);
    repeat (LAT - 2) tick();
    check("rerise_pre", key_ef, 4'h0);
    tick();
    check("rerise", key_ef, 4'h4);

    // Randomised pads and CPU writes against the model
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 15))
        0: keys_p1 = 10'($urandom);
        1: keys_p1[$urandom_range(0, 9)] = ~keys_p1[$urandom_range(0, 9)];
        2: keys_p2 = 10'($urandom);
        3: keys_p2[$urandom_range(0, 9)] = ~keys_p2[$urandom_range(0, 9)];
        default: ;
      endcase
      if ($urandom_range(0, 9) == 0) begin
        io_out  = 1'b1;
        io_n    = ($urandom_range(0, 1) == 1) ? 3'd2 : 3'($urandom_range(0, 7));
        io_dout = 8'($urandom);
      end else begin
        io_out  = 1'b0;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
